// File: rtl/gencon_calc.sv
// gencon_calc: sequencing controller and datapath for a signed keypad calculator.
// Ports: clk, nRST (sync, active-high); keypad_input/read_input digit strobe;
//        operator_input command; equal_input level request; complete pulse,
//        display_output operand/result, tb_current_state FSM debug.
// Latency: digit visible next cycle; equal sampled at edge N -> complete after N+1.
// Backpressure: none; every strobe is consumed or dropped in the cycle it arrives.
module gencon_calc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             complete,
  output logic [WIDTH-1:0] display_output,
  output logic [1:0]       tb_current_state
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2,
    ENTER_B = 2'd3
  } state_t;

  localparam logic [2:0] OP_SIGN = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  // Set once a calculation completes: display keeps the result and the next
  // A digit/toggle starts a fresh operand instead of extending the old one.
  logic             hold_q, hold_d;

  logic                    digit_ok;
  logic                    is_arith;
  logic [WIDTH-1:0]        a_val, b_val;
  logic signed [2*WIDTH-1:0] product;

  // mag*10 + digit, wrapping at WIDTH bits.
  function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] mag,
                                             input logic [3:0] key);
    return (mag << 3) + (mag << 1) + WIDTH'(key);
  endfunction

  function automatic logic [WIDTH-1:0] to_signed(input logic [WIDTH-1:0] mag,
                                                 input logic neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign digit_ok = (keypad_input <= 4'd9);
  assign is_arith = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                    (operator_input == OP_MUL);
  assign a_val    = to_signed(a_mag_q, a_neg_q);
  assign b_val    = to_signed(b_mag_q, b_neg_q);
  // Operands are extended to 2*WIDTH signed before multiplying.
  assign product  = $signed(a_val) * $signed(b_val);

  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    a_neg_d  = a_neg_q;
    b_mag_d  = b_mag_q;
    b_neg_d  = b_neg_q;
    op_d     = op_q;
    result_d = result_q;
    hold_d   = hold_q;
    case (state_q)
      ENTER_A: begin
        if (read_input) begin
          if (digit_ok) begin
            a_mag_d = mac10(hold_q ? '0 : a_mag_q, keypad_input);
            if (hold_q) begin
              a_neg_d = 1'b0;
              op_d    = 3'b000;
            end
            hold_d = 1'b0;
          end
        end else if (operator_input == OP_SIGN) begin
          if (hold_q) begin
            a_mag_d = '0;
            op_d    = 3'b000;
          end
          a_neg_d = hold_q ? 1'b1 : ~a_neg_q;
          hold_d  = 1'b0;
        end else if (is_arith) begin
          op_d    = operator_input;
          b_mag_d = '0;
          b_neg_d = 1'b0;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (read_input) begin
          if (digit_ok) b_mag_d = mac10(b_mag_q, keypad_input);
        end else if (operator_input == OP_SIGN) begin
          b_neg_d = ~b_neg_q;
        end else if (equal_input) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        case (op_q)
          OP_SUB:  result_d = a_val - b_val;
          OP_MUL:  result_d = product[WIDTH-1:0];
          default: result_d = a_val + b_val;
        endcase
        hold_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = ENTER_A;  // DONE: always back to entry
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q  <= ENTER_A;
      a_mag_q  <= '0;
      a_neg_q  <= 1'b0;
      b_mag_q  <= '0;
      b_neg_q  <= 1'b0;
      op_q     <= 3'b000;
      result_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_mag_q  <= a_mag_d;
      a_neg_q  <= a_neg_d;
      b_mag_q  <= b_mag_d;
      b_neg_q  <= b_neg_d;
      op_q     <= op_d;
      result_q <= result_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_A: display_output = hold_q ? result_q : a_val;
      DONE:    display_output = result_q;
      default: display_output = b_val;  // B entry, and B held while computing
    endcase
  end

  assign complete         = (state_q == DONE);
  assign tb_current_state = state_q;

endmodule

// File: tb/tb_gencon_calc.sv
module tb_gencon_calc;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  logic [1:0]  tb_current_state;

  always #5 clk = ~clk;

  gencon_calc #(.WIDTH(16)) dut (
    .clk             (clk),
    .nRST            (nRST),
    .keypad_input    (keypad_input),
    .read_input      (read_input),
    .operator_input  (operator_input),
    .equal_input     (equal_input),
    .complete        (complete),
    .display_output  (display_output),
    .tb_current_state(tb_current_state)
  );

  int errors = 0;
  int checks = 0;
  int npulse = 0;

  // Reference model: phase 0 A entry, 1 compute, 2 done, 3 B entry.
  int m_phase = 0;
  int m_amag = 0, m_bmag = 0, m_op = 0, m_res = 0;
  bit m_aneg = 0, m_bneg = 0, m_fresh = 0;

  function automatic int sval(input int mag, input bit neg);
    int v;
    v = neg ? ((-mag) & 65535) : mag;
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic void model_step(input bit rst, input int key, input bit rd,
                                     input int op, input bit eq);
    int sa, sb;
    if (rst) begin
      m_phase = 0; m_amag = 0; m_bmag = 0; m_op = 0; m_res = 0;
      m_aneg = 0; m_bneg = 0; m_fresh = 0;
      return;
    end
    sa = sval(m_amag, m_aneg);
    sb = sval(m_bmag, m_bneg);
    if (m_phase == 0) begin
      if (rd) begin
        if (key <= 9) begin
          if (m_fresh) begin m_amag = 0; m_aneg = 0; m_op = 0; m_fresh = 0; end
          m_amag = (m_amag * 10 + key) % 65536;
        end
      end else if (op == 1) begin
        if (m_fresh) begin m_amag = 0; m_aneg = 0; m_op = 0; m_fresh = 0; end
        m_aneg = !m_aneg;
      end else if (op >= 2 && op <= 4) begin
        m_op = op; m_bmag = 0; m_bneg = 0; m_phase = 3;
      end
    end else if (m_phase == 3) begin
      if (rd) begin
        if (key <= 9) m_bmag = (m_bmag * 10 + key) % 65536;
      end else if (op == 1) m_bneg = !m_bneg;
      else if (eq) m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_op == 3)      m_res = (sa - sb) & 65535;
      else if (m_op == 4) m_res = (sa * sb) & 65535;
      else                m_res = (sa + sb) & 65535;
      m_fresh = 1;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endfunction

  function automatic int model_disp();
    if (m_phase == 0) return m_fresh ? m_res : (sval(m_amag, m_aneg) & 65535);
    if (m_phase == 2) return m_res;
    return sval(m_bmag, m_bneg) & 65535;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, advance model at the edge, compare 1 time unit later.
  task automatic cyc(input bit rst, input int key, input bit rd, input int op, input bit eq);
    nRST = rst; keypad_input = 4'(key); read_input = rd;
    operator_input = 3'(op); equal_input = eq;
    @(posedge clk);
    model_step(rst, key, rd, op, eq);
    #1;
    check("display", int'(display_output), model_disp());
    check("complete", int'(complete), (m_phase == 2) ? 1 : 0);
    check("state", int'(tb_current_state), m_phase);
    if (complete) npulse++;
  endtask

  task automatic idle();                  cyc(0, 0, 0, 0, 0); endtask
  task automatic press(input int d);      cyc(0, d, 1, 0, 0); endtask
  task automatic cmd(input int o);        cyc(0, 0, 0, o, 0); endtask

  task automatic enter_num(input int v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) press(int'(s[i]) - 48);
  endtask

  typedef struct {
    bit          an;
    int          a;
    int          op;
    bit          bn;
    int          b;
    logic [15:0] exp;
  } vec_t;

  task automatic calc(input vec_t v);
    bit seen;
    int lat;
    if (v.an) cmd(1);
    enter_num(v.a);
    cmd(v.op);
    if (v.bn) cmd(1);
    enter_num(v.b);
    npulse = 0;
    seen = 0;
    lat = -1;
    // equal held high through completion and beyond
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (complete) begin
        seen = 1;
        lat = i;
        check("result", int'(display_output), int'(v.exp));
      end
    end
    check("complete_seen", int'(seen), 1);
    check("latency", lat, 1);
    cyc(0, 0, 0, 0, 1);
    idle();
    idle();
    check("pulse_count", npulse, 1);
    check("held_result", int'(display_output), int'(v.exp));
    check("back_to_a", int'(tb_current_state), 0);
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    tbl[0] = '{0, 2,     2, 0, 3,     16'h0005};
    tbl[1] = '{1, 10,    2, 0, 10,    16'h0000};
    tbl[2] = '{1, 25,    2, 1, 15,    16'hFFD8};
    tbl[3] = '{1, 32768, 2, 0, 32767, 16'hFFFF};
    tbl[4] = '{1, 12,    4, 0, 3000,  16'h7360};
    tbl[5] = '{0, 128,   4, 0, 256,   16'h8000};
    tbl[6] = '{0, 3,     3, 0, 5,     16'hFFFE};

    nRST = 1; keypad_input = 0; read_input = 0; operator_input = 0; equal_input = 0;

    // Reset with every other input active: reset must win.
    cyc(1, 7, 1, 2, 1);
    check("rst_display", int'(display_output), 0);
    check("rst_complete", int'(complete), 0);
    check("rst_state", int'(tb_current_state), 0);

    for (int i = 0; i < 7; i++) calc(tbl[i]);

    // Reset during B entry with equal held high.
    cyc(1, 0, 0, 0, 0);
    press(5); cmd(2); press(7);
    npulse = 0;
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    check("rst_mid_pulses", npulse, 0);
    check("rst_mid_state", int'(tb_current_state), 0);
    check("rst_mid_display", int'(display_output), 0);
    idle();
    v = '{0, 4, 4, 0, 5, 16'h0014};
    calc(v);

    // Out-of-range digit is ignored; digit beats a same-cycle operator.
    cyc(1, 0, 0, 0, 0);
    press(1);
    cyc(0, 12, 1, 0, 0);
    check("digit_gt9", int'(display_output), 1);
    cyc(0, 3, 1, 2, 0);
    check("prio_digit_disp", int'(display_output), 13);
    check("prio_digit_state", int'(tb_current_state), 0);
    cmd(2);
    cyc(0, 2, 1, 0, 1);
    check("prio_eq_dropped", int'(tb_current_state), 3);
    check("prio_b_disp", int'(display_output), 2);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int kind, key, op;
      bit rst;
      rst  = ($urandom_range(0, 249) == 0);
      kind = $urandom_range(0, 9);
      key  = $urandom_range(0, 9);
      op   = $urandom_range(0, 7);
      if (kind <= 2)      cyc(rst, key, 1, ($urandom_range(0, 3) == 0) ? op : 0, 0);
      else if (kind == 3) cyc(rst, $urandom_range(10, 15), 1, 0, 0);
      else if (kind <= 5) cyc(rst, 0, 0, op, 0);
      else if (kind <= 7) cyc(rst, key, 0, 0, 1);
      else                cyc(rst, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
